// File: rtl/shadow_pkg.sv
// Shared definitions for the shadow-model compare logger.
//   state_t  : logger FSM encoding (IDLE=0, SETTLE=1, RUN=2, FROZEN=3)
//   event_t  : logged event record {ts, diff} at the default widths
//   *_LSB    : lane-packing offsets of the compared vector, shared with the tracer top
//   lane_of  : maps a compared bit index to its lane (0 ctrl, 1 addr, 2 data)
package shadow_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_FROZEN = 2'd3
  } state_t;

  localparam int unsigned DEF_W    = 32;
  localparam int unsigned DEF_TS_W = 24;

  typedef struct packed {
    logic [DEF_TS_W-1:0] ts;
    logic [DEF_W-1:0]    diff;
  } event_t;

  // Caller packs ctrl in [ADDR_LSB-1:CTRL_LSB], addr in [DATA_LSB-1:ADDR_LSB],
  // data from DATA_LSB upwards.
  localparam int unsigned CTRL_LSB = 0;
  localparam int unsigned ADDR_LSB = 4;
  localparam int unsigned DATA_LSB = 16;

  function automatic logic [1:0] lane_of(input int unsigned bit_idx);
    logic [1:0] lane;
    if (bit_idx >= DATA_LSB) begin
      lane = 2'd2;
    end else if (bit_idx >= ADDR_LSB) begin
      lane = 2'd1;
    end else if (bit_idx >= CTRL_LSB) begin
      lane = 2'd0;
    end else begin
      lane = 2'd3;
    end
    return lane;
  endfunction

endpackage

// File: rtl/shadow_event_fifo.sv
// Synchronous event FIFO, DEPTH x DW, no fall-through.
// The head entry is held in a register so that it is 0 after reset/clear and
// keeps its last value while the FIFO is empty.
// Ports:
//   CLK_n    clock, rising edge
//   RESET_n  asynchronous active-low reset
//   clr      synchronous clear (dominates push/pop)
//   push     write wdata (accepted when not full, or full with a pop)
//   pop      drop head (ignored when empty)
//   wdata    entry to write
//   full     DEPTH entries stored
//   empty    no entries stored
//   rdata    registered head entry
module shadow_event_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 56
) (
  input  logic          CLK_n,
  input  logic          RESET_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   cnt_r;
  logic [DW-1:0] head_r;

  logic          pop_s;
  logic          push_s;
  logic          full_s;
  logic          empty_s;
  logic [AW-1:0] rd_nxt_s;

  // Qualify push/pop against occupancy; a full FIFO still accepts a push when it pops.
  always_comb begin
    empty_s  = (cnt_r == '0);
    full_s   = (cnt_r == (AW+1)'(DEPTH));
    pop_s    = pop && !empty_s;
    push_s   = push && (!full_s || pop_s);
    rd_nxt_s = rd_ptr_r + AW'(1);
  end

  // Pointers, occupancy and registered head entry.
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      head_r   <= '0;
    end else if (clr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      head_r   <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_nxt_s;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
        2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
      // New head is the pushed word when it lands in an (effectively) empty
      // FIFO, otherwise the next stored entry after a pop.
      if (push_s && (empty_s || (pop_s && cnt_r == (AW+1)'(1)))) begin
        head_r <= wdata;
      end else if (pop_s && cnt_r >= (AW+1)'(2)) begin
        head_r <= mem_r[rd_nxt_s];
      end
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge CLK_n) begin
    if (push_s && !clr) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign full  = full_s;
  assign empty = empty_s;
  assign rdata = head_r;

endmodule

// File: rtl/shadow_compare_logger.sv
// Shadow-model pin comparator with mismatch statistics, run trigger and a
// timestamped event log drained over a valid/ready port.
// Ports:
//   CLK_n, RESET_n          clock (rising edge) / async active-low reset
//   arm                     sync pulse: clear stats, FIFO, timestamp; restart
//   shadow, actual, care    model value, observed value, per-bit compare enable
//   ignore                  whole-cycle ignore from the model
//   match                   1 = last sampled cycle matched (forced 1 outside RUN)
//   sticky_mismatch         any mismatch since arm
//   mismatch_count          saturating count of mismatching cycles
//   trigger                 sticky, TRIG_RUN consecutive mismatches seen
//   overflow                sticky, an event was dropped on a full FIFO
//   state                   IDLE=0, SETTLE=1, RUN=2, FROZEN=3
//   rd_valid/rd_ready       event FIFO head handshake
//   rd_ts, rd_diff          head event timestamp and diff bits
module shadow_compare_logger
  import shadow_pkg::*;
#(
  parameter int W            = 32,
  parameter int TS_W         = 24,
  parameter int DEPTH        = 16,
  parameter int CNT_W        = 16,
  parameter int SETTLE       = 2,
  parameter int TRIG_RUN     = 4,
  parameter int LOG_MODE     = 0,
  parameter int STOP_ON_TRIG = 1
) (
  input  logic             CLK_n,
  input  logic             RESET_n,
  input  logic             arm,
  input  logic [W-1:0]     shadow,
  input  logic [W-1:0]     actual,
  input  logic [W-1:0]     care,
  input  logic             ignore,
  output logic             match,
  output logic             sticky_mismatch,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             trigger,
  output logic             overflow,
  output logic [1:0]       state,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [TS_W-1:0]  rd_ts,
  output logic [W-1:0]     rd_diff
);

  localparam int RUN_W = $clog2(TRIG_RUN + 1);

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [W-1:0]    diff;
  } evt_t;

  state_t           state_r;
  logic [TS_W-1:0]  ts_r;
  logic [RUN_W-1:0] run_r;
  logic [W-1:0]     prev_diff_r;
  logic             prev_miss_r;
  logic             match_r;
  logic             sticky_r;
  logic             trig_r;
  logic             ovf_r;
  logic [CNT_W-1:0] cnt_r;

  logic [W-1:0]     diff_s;
  logic             miss_s;
  logic             trig_hit_s;
  logic             log_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  evt_t             wevt_s;
  evt_t             revt_s;

  // Per-edge compare, trigger detection and log/FIFO strobes.
  always_comb begin
    diff_s     = (shadow ^ actual) & care;
    miss_s     = (diff_s != '0) && !ignore && (state_r == ST_RUN);
    // run_r holds the misses before this edge, so this miss completes the run.
    trig_hit_s = miss_s && (run_r == RUN_W'(TRIG_RUN - 1));
    if (LOG_MODE == 0) begin
      log_s = miss_s;
    end else begin
      log_s = miss_s && (!prev_miss_r || (diff_s != prev_diff_r));
    end
    // arm clears the FIFO on this edge, so any coincident push/pop is void.
    push_s      = log_s && !arm;
    pop_s       = !empty_s && rd_ready && !arm;
    wevt_s.ts   = ts_r;
    wevt_s.diff = diff_s;
  end

  shadow_event_fifo #(
    .DEPTH (DEPTH),
    .DW    (TS_W + W)
  ) u_fifo (
    .CLK_n   (CLK_n),
    .RESET_n (RESET_n),
    .clr     (arm),
    .push    (push_s),
    .pop     (pop_s),
    .wdata   (wevt_s),
    .full    (full_s),
    .empty   (empty_s),
    .rdata   (revt_s)
  );

  // FSM, timestamp, run counter and sticky statistics.
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      state_r     <= ST_IDLE;
      ts_r        <= '0;
      run_r       <= '0;
      prev_diff_r <= '0;
      prev_miss_r <= 1'b0;
      match_r     <= 1'b1;
      sticky_r    <= 1'b0;
      trig_r      <= 1'b0;
      ovf_r       <= 1'b0;
      cnt_r       <= '0;
    end else if (arm) begin
      state_r     <= (SETTLE == 0) ? ST_RUN : ST_SETTLE;
      ts_r        <= '0;
      run_r       <= '0;
      prev_diff_r <= '0;
      prev_miss_r <= 1'b0;
      match_r     <= 1'b1;
      sticky_r    <= 1'b0;
      trig_r      <= 1'b0;
      ovf_r       <= 1'b0;
      cnt_r       <= '0;
    end else begin
      match_r     <= !miss_s;
      prev_miss_r <= miss_s;
      prev_diff_r <= diff_s;
      if (miss_s) begin
        sticky_r <= 1'b1;
        if (cnt_r != '1) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
        // Saturate so a long run with STOP_ON_TRIG=0 cannot wrap and re-hit.
        if (run_r != RUN_W'(TRIG_RUN)) begin
          run_r <= run_r + RUN_W'(1);
        end
      end else begin
        run_r <= '0;
      end
      if (trig_hit_s) begin
        trig_r <= 1'b1;
      end
      if (push_s && full_s && !pop_s) begin
        ovf_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_SETTLE: begin
          // The timestamp starts at 0 in SETTLE, so it doubles as the settle count.
          ts_r <= ts_r + TS_W'(1);
          if (ts_r == TS_W'(SETTLE - 1)) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          ts_r <= ts_r + TS_W'(1);
          if (trig_hit_s && (STOP_ON_TRIG != 0)) begin
            state_r <= ST_FROZEN;
          end
        end
        ST_FROZEN: begin
          state_r <= ST_FROZEN;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign match           = match_r;
  assign sticky_mismatch = sticky_r;
  assign mismatch_count  = cnt_r;
  assign trigger         = trig_r;
  assign overflow        = ovf_r;
  assign state           = state_r;
  assign rd_valid        = !empty_s;
  assign rd_ts           = revt_s.ts;
  assign rd_diff         = revt_s.diff;

endmodule

// File: tb/tb_shadow_compare_logger.sv
// Directed bench for shadow_compare_logger.
// u0: default configuration (LOG_MODE 0, CNT_W 16).
// u1: same stimulus, CNT_W 4 and LOG_MODE 1, for saturation and onset logging.
module tb_shadow_compare_logger;

  localparam logic [31:0] FULL = 32'hFFFF_FFFF;

  logic        CLK_n;
  logic        RESET_n;
  logic        arm;
  logic [31:0] shadow;
  logic [31:0] actual;
  logic [31:0] care;
  logic        ignore;
  logic        rd_ready;

  logic        m0, stk0, trg0, ovf0, v0;
  logic [15:0] cnt0;
  logic [1:0]  st0;
  logic [23:0] ts0;
  logic [31:0] df0;

  logic        m1, stk1, trg1, ovf1, v1;
  logic [3:0]  cnt1;
  logic [1:0]  st1;
  logic [23:0] ts1;
  logic [31:0] df1;

  int n_checks = 0;
  int n_errors = 0;

  shadow_compare_logger u0 (
    .CLK_n(CLK_n), .RESET_n(RESET_n), .arm(arm), .shadow(shadow), .actual(actual),
    .care(care), .ignore(ignore), .match(m0), .sticky_mismatch(stk0),
    .mismatch_count(cnt0), .trigger(trg0), .overflow(ovf0), .state(st0),
    .rd_valid(v0), .rd_ready(rd_ready), .rd_ts(ts0), .rd_diff(df0)
  );

  shadow_compare_logger #(.CNT_W(4), .LOG_MODE(1)) u1 (
    .CLK_n(CLK_n), .RESET_n(RESET_n), .arm(arm), .shadow(shadow), .actual(actual),
    .care(care), .ignore(ignore), .match(m1), .sticky_mismatch(stk1),
    .mismatch_count(cnt1), .trigger(trg1), .overflow(ovf1), .state(st1),
    .rd_valid(v1), .rd_ready(rd_ready), .rd_ts(ts1), .rd_diff(df1)
  );

  initial begin
    CLK_n = 1'b0;
    forever #5 CLK_n = ~CLK_n;
  end

  typedef struct {
    logic        arm;
    logic [31:0] pat;
    logic [31:0] care;
    logic        ign;
    logic        rdy;
    logic [1:0]  e_st;
    logic        e_m;
    logic [15:0] e_cnt;
    logic        e_stk;
    logic        e_trg;
    logic        e_v;
    logic [23:0] e_ts;
  } vec_t;

  vec_t tbl[$];
  int   q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic a, input logic [31:0] p, input logic [31:0] c,
                     input logic ig, input logic rd, input logic [1:0] st, input logic m,
                     input logic [15:0] cnt, input logic stk, input logic trg,
                     input logic v, input logic [23:0] ts);
    vec_t e;
    e.arm = a; e.pat = p; e.care = c; e.ign = ig; e.rdy = rd;
    e.e_st = st; e.e_m = m; e.e_cnt = cnt; e.e_stk = stk; e.e_trg = trg;
    e.e_v = v; e.e_ts = ts;
    tbl.push_back(e);
  endtask

  task automatic step(input logic a, input logic [31:0] p, input logic [31:0] c,
                      input logic ig, input logic rd);
    arm      = a;
    shadow   = $urandom;
    actual   = shadow ^ p;
    care     = c;
    ignore   = ig;
    rd_ready = rd;
    @(posedge CLK_n);
    #1;
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, " u0 state"}, {30'd0, st0}, 32'd1);
    chk({nm, " u0 match"}, {31'd0, m0}, 32'd1);
    chk({nm, " u0 count"}, {16'd0, cnt0}, 32'd0);
    chk({nm, " u0 sticky"}, {31'd0, stk0}, 32'd0);
    chk({nm, " u0 trigger"}, {31'd0, trg0}, 32'd0);
    chk({nm, " u0 overflow"}, {31'd0, ovf0}, 32'd0);
    chk({nm, " u0 rd_valid"}, {31'd0, v0}, 32'd0);
    chk({nm, " u0 rd_ts"}, {8'd0, ts0}, 32'd0);
    chk({nm, " u1 count"}, {28'd0, cnt1}, 32'd0);
    chk({nm, " u1 rd_valid"}, {31'd0, v1}, 32'd0);
  endtask

  initial begin
    int n0;
    int n1;
    int exp_cnt;
    logic miss;
    logic popping;

    RESET_n = 1'b0; arm = 1'b0; shadow = 32'd0; actual = 32'd0;
    care = FULL; ignore = 1'b0; rd_ready = 1'b0;
    #12;
    // Reset values
    chk("rst state", {30'd0, st0}, 32'd0);
    chk("rst match", {31'd0, m0}, 32'd1);
    chk("rst count", {16'd0, cnt0}, 32'd0);
    chk("rst sticky", {31'd0, stk0}, 32'd0);
    chk("rst trigger", {31'd0, trg0}, 32'd0);
    chk("rst overflow", {31'd0, ovf0}, 32'd0);
    chk("rst rd_valid", {31'd0, v0}, 32'd0);
    chk("rst rd_ts", {8'd0, ts0}, 32'd0);
    chk("rst rd_diff", df0, 32'd0);
    RESET_n = 1'b1;

    // IDLE ignores mismatches until armed.
    step(1'b0, 32'h1, FULL, 1'b0, 1'b0);
    chk("idle state", {30'd0, st0}, 32'd0);
    chk("idle count", {16'd0, cnt0}, 32'd0);

    // ---- table: arm, settle, single error, care/ignore, broken runs, re-arm, trigger
    add(1, 0, FULL, 0, 0, 2'd1, 1, 0, 0, 0, 0, 0);
    add(0, 0, FULL, 0, 0, 2'd1, 1, 0, 0, 0, 0, 0);
    add(0, 0, FULL, 0, 0, 2'd2, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) add(0, 0, FULL, 0, 0, 2'd2, 1, 0, 0, 0, 0, 0);
    add(0, 32'h8, FULL, 0, 0, 2'd2, 0, 1, 1, 0, 1, 24'd12);
    add(0, 0, FULL, 0, 0, 2'd2, 1, 1, 1, 0, 1, 24'd12);
    add(0, 0, FULL, 0, 1, 2'd2, 1, 1, 1, 0, 0, 24'd12);
    add(0, 32'h8, ~32'h8, 0, 0, 2'd2, 1, 1, 1, 0, 0, 24'd12);
    add(0, 32'h8, FULL, 1, 0, 2'd2, 1, 1, 1, 0, 0, 24'd12);
    add(0, 32'h8, FULL, 0, 0, 2'd2, 0, 2, 1, 0, 1, 24'd17);
    add(0, 32'h8, FULL, 0, 0, 2'd2, 0, 3, 1, 0, 1, 24'd17);
    add(0, 32'h8, FULL, 0, 0, 2'd2, 0, 4, 1, 0, 1, 24'd17);
    add(0, 32'h8, FULL, 1, 0, 2'd2, 1, 4, 1, 0, 1, 24'd17);
    add(0, 32'h8, FULL, 0, 0, 2'd2, 0, 5, 1, 0, 1, 24'd17);
    add(0, 32'h8, FULL, 0, 0, 2'd2, 0, 6, 1, 0, 1, 24'd17);
    add(0, 32'h8, FULL, 0, 0, 2'd2, 0, 7, 1, 0, 1, 24'd17);
    add(0, 0, FULL, 0, 0, 2'd2, 1, 7, 1, 0, 1, 24'd17);
    add(1, 0, FULL, 0, 0, 2'd1, 1, 0, 0, 0, 0, 0);
    add(0, 0, FULL, 0, 0, 2'd1, 1, 0, 0, 0, 0, 0);
    add(0, 0, FULL, 0, 0, 2'd2, 1, 0, 0, 0, 0, 0);
    add(0, 32'h10, FULL, 0, 0, 2'd2, 0, 1, 1, 0, 1, 24'd2);
    add(0, 32'h10, FULL, 0, 0, 2'd2, 0, 2, 1, 0, 1, 24'd2);
    add(0, 32'h10, FULL, 0, 0, 2'd2, 0, 3, 1, 0, 1, 24'd2);
    add(0, 32'h10, FULL, 0, 0, 2'd3, 0, 4, 1, 1, 1, 24'd2);
    add(0, 32'h10, FULL, 0, 0, 2'd3, 1, 4, 1, 1, 1, 24'd2);

    foreach (tbl[i]) begin
      step(tbl[i].arm, tbl[i].pat, tbl[i].care, tbl[i].ign, tbl[i].rdy);
      chk($sformatf("row%0d state", i), {30'd0, st0}, {30'd0, tbl[i].e_st});
      chk($sformatf("row%0d match", i), {31'd0, m0}, {31'd0, tbl[i].e_m});
      chk($sformatf("row%0d count", i), {16'd0, cnt0}, {16'd0, tbl[i].e_cnt});
      chk($sformatf("row%0d sticky", i), {31'd0, stk0}, {31'd0, tbl[i].e_stk});
      chk($sformatf("row%0d trigger", i), {31'd0, trg0}, {31'd0, tbl[i].e_trg});
      chk($sformatf("row%0d rd_valid", i), {31'd0, v0}, {31'd0, tbl[i].e_v});
      chk($sformatf("row%0d rd_ts", i), {8'd0, ts0}, {8'd0, tbl[i].e_ts});
      chk($sformatf("row%0d u1 state", i), {30'd0, st1}, {30'd0, tbl[i].e_st});
      chk($sformatf("row%0d u1 count", i), {28'd0, cnt1}, {16'd0, tbl[i].e_cnt});
      chk($sformatf("row%0d u1 rd_valid", i), {31'd0, v1}, {31'd0, tbl[i].e_v});
    end

    // ---- drain after trigger: u0 logged all 4 misses, u1 only the onset
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 8; k++) begin
      if (v0) begin
        chk("trig drain u0 ts", {8'd0, ts0}, 32'(2 + n0));
        chk("trig drain u0 diff", df0, 32'h10);
        n0++;
      end
      if (v1) begin
        chk("trig drain u1 ts", {8'd0, ts1}, 32'd2);
        n1++;
      end
      step(1'b0, 32'h10, FULL, 1'b0, 1'b1);
    end
    chk("trig u0 entries", 32'(n0), 32'd4);
    chk("trig u1 entries", 32'(n1), 32'd1);
    chk("frozen count", {16'd0, cnt0}, 32'd4);

    // ---- overflow: 20 misses in runs of 3, consumer stalled except one edge
    step(1'b1, 32'd0, FULL, 1'b0, 1'b0);
    chk_cleared("rearm");
    step(1'b0, 32'd0, FULL, 1'b0, 1'b0);
    step(1'b0, 32'd0, FULL, 1'b0, 1'b0);
    exp_cnt = 0;
    for (int i = 0; i < 26; i++) begin
      miss    = ((i % 4) != 3);
      popping = (i == 21) && (q.size() > 0);
      if (popping) begin
        chk("ovf pop head", {8'd0, ts0}, 32'(q[0]));
      end
      step(1'b0, miss ? 32'(i + 1) : 32'd0, FULL, 1'b0, (i == 21));
      if (miss && (q.size() < 16 || popping)) begin
        if (popping) void'(q.pop_front());
        q.push_back(2 + i);
      end else if (popping) begin
        void'(q.pop_front());
      end
      if (miss) exp_cnt++;
      chk($sformatf("ovf count i=%0d", i), {16'd0, cnt0}, 32'(exp_cnt));
      if (i == 20) chk("full no ovf", {31'd0, ovf0}, 32'd0);
      if (i == 21) chk("full push+pop no ovf", {31'd0, ovf0}, 32'd0);
      if (i == 22) chk("full push ovf", {31'd0, ovf0}, 32'd1);
    end
    chk("ovf final count", {16'd0, cnt0}, 32'd20);
    chk("u1 saturated count", {28'd0, cnt1}, 32'd15);
    chk("ovf trigger", {31'd0, trg0}, 32'd0);
    chk("ovf state", {30'd0, st0}, 32'd2);

    for (int k = 0; k < 8; k++) begin
      chk("ovf drain valid", {31'd0, v0}, 32'd1);
      chk("ovf drain ts", {8'd0, ts0}, 32'(q[0]));
      chk("ovf drain diff", df0, 32'(q[0] - 1));
      void'(q.pop_front());
      step(1'b0, 32'd0, FULL, 1'b0, 1'b1);
    end

    // ---- arm with FIFO non-empty, u1 saturated, and a coincident pop
    step(1'b1, 32'd0, FULL, 1'b0, 1'b1);
    chk_cleared("arm mid-run");

    // ---- async reset while an event is waiting
    step(1'b0, 32'd0, FULL, 1'b0, 1'b0);
    step(1'b0, 32'd0, FULL, 1'b0, 1'b0);
    step(1'b0, 32'h1, FULL, 1'b0, 1'b0);
    chk("pre-reset valid", {31'd0, v0}, 32'd1);
    chk("pre-reset match", {31'd0, m0}, 32'd0);
    rd_ready = 1'b1;
    #1;
    RESET_n = 1'b0;
    #1;
    chk("async rst rd_valid", {31'd0, v0}, 32'd0);
    chk("async rst match", {31'd0, m0}, 32'd1);
    chk("async rst state", {30'd0, st0}, 32'd0);
    chk("async rst count", {16'd0, cnt0}, 32'd0);
    chk("async rst sticky", {31'd0, stk0}, 32'd0);
    chk("async rst rd_ts", {8'd0, ts0}, 32'd0);
    chk("async rst u1 rd_valid", {31'd0, v1}, 32'd0);
    #10;
    RESET_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
